// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one main-memory port between the I-cache and the
// D-cache. A miss becomes a sequential block fill (one word issued per cycle,
// with returns steered to the owning cache). A D-side write-through becomes a
// single-word write.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   IReq/IAddr               I-cache miss request, held until IDone
//   DReq/DWr/DAddr/DDataIn   D-cache fill or write request, held until DDone
//   MemDataIn/MemDataValid   in-order read returns from main memory
//   MemAddr/MemDataOut/
//   MemEnable/MemWrite       registered main-memory command
//   FillData/FillWordIdx     returned word and its index in the block
//   IFillValid/DFillValid    FillData belongs to the I-cache / D-cache
//   IDone/DDone              one-cycle completion pulses
module memory_arbiter #(
  parameter  int WORDS_PER_BLOCK = 8,
  parameter  int ADDR_WIDTH      = 16,
  localparam int IDX_W           = $clog2(WORDS_PER_BLOCK),
  localparam int OFF_W           = IDX_W + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  IReq,
  input  logic [ADDR_WIDTH-1:0] IAddr,
  input  logic                  DReq,
  input  logic                  DWr,
  input  logic [ADDR_WIDTH-1:0] DAddr,
  input  logic [15:0]           DDataIn,
  input  logic [15:0]           MemDataIn,
  input  logic                  MemDataValid,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [15:0]           MemDataOut,
  output logic                  MemEnable,
  output logic                  MemWrite,
  output logic [15:0]           FillData,
  output logic [IDX_W-1:0]      FillWordIdx,
  output logic                  IFillValid,
  output logic                  DFillValid,
  output logic                  IDone,
  output logic                  DDone
);

  typedef enum logic [2:0] {IDLE, I_FILL, D_FILL, D_WRITE, DONE} state_t;

  localparam logic [IDX_W:0]   NWORDS   = (IDX_W+1)'(WORDS_PER_BLOCK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  state_t                     state;
  logic                       last_d;     // last owner: 1 = D-side, 0 = I-side
  logic [ADDR_WIDTH-OFF_W-1:0] blk;       // block address latched at grant
  logic [IDX_W:0]             issue_cnt;  // words issued so far (0..WORDS)
  logic [IDX_W-1:0]           ret_cnt;    // words returned so far

  // Byte-offset bits of the request addresses are not needed for fills.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{IAddr[OFF_W-1:0], DAddr[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_d     <= 1'b0;
      blk        <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      MemAddr    <= '0;
      MemDataOut <= '0;
      MemEnable  <= 1'b0;
      MemWrite   <= 1'b0;
      IDone      <= 1'b0;
      DDone      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // On conflict serve the side that did not go last.
          if (DReq && (!IReq || !last_d)) begin
            last_d <= 1'b1;
            if (DWr) begin
              state      <= D_WRITE;
              MemAddr    <= {DAddr[ADDR_WIDTH-1:1], 1'b0};
              MemDataOut <= DDataIn;
              MemEnable  <= 1'b1;
              MemWrite   <= 1'b1;
            end else begin
              state     <= D_FILL;
              blk       <= DAddr[ADDR_WIDTH-1:OFF_W];
              MemAddr   <= {DAddr[ADDR_WIDTH-1:OFF_W], {IDX_W{1'b0}}, 1'b0};
              MemEnable <= 1'b1;
              issue_cnt <= (IDX_W+1)'(1);
              ret_cnt   <= '0;
            end
          end else if (IReq) begin
            last_d    <= 1'b0;
            state     <= I_FILL;
            blk       <= IAddr[ADDR_WIDTH-1:OFF_W];
            MemAddr   <= {IAddr[ADDR_WIDTH-1:OFF_W], {IDX_W{1'b0}}, 1'b0};
            MemEnable <= 1'b1;
            issue_cnt <= (IDX_W+1)'(1);
            ret_cnt   <= '0;
          end
        end

        I_FILL, D_FILL: begin
          // Issue side: one word per cycle until the block is fully requested.
          if (issue_cnt < NWORDS) begin
            MemAddr   <= {blk, issue_cnt[IDX_W-1:0], 1'b0};
            issue_cnt <= issue_cnt + 1'b1;
          end else begin
            MemEnable <= 1'b0;
            MemAddr   <= '0;
          end
          // Return side: runs independently since returns overlap issues.
          if (MemDataValid) begin
            ret_cnt <= ret_cnt + 1'b1;
            if (ret_cnt == LAST_IDX) begin
              state     <= DONE;
              MemEnable <= 1'b0;
              MemAddr   <= '0;
              if (state == D_FILL) DDone <= 1'b1;
              else                 IDone <= 1'b1;
            end
          end
        end

        D_WRITE: begin
          state      <= DONE;
          MemAddr    <= '0;
          MemDataOut <= '0;
          MemEnable  <= 1'b0;
          MemWrite   <= 1'b0;
          DDone      <= 1'b1;
        end

        DONE: begin
          state <= IDLE;
          IDone <= 1'b0;
          DDone <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Read returns pass straight through to the owning cache in the same cycle.
  logic fill_hit;
  assign fill_hit    = MemDataValid && (state == I_FILL || state == D_FILL);
  assign IFillValid  = fill_hit && (state == I_FILL);
  assign DFillValid  = fill_hit && (state == D_FILL);
  assign FillData    = fill_hit ? MemDataIn : 16'h0000;
  assign FillWordIdx = fill_hit ? ret_cnt : '0;

endmodule
